lcd_frame_scheduler: RTL
========================

Name: lcd_frame_scheduler

Overview:
Shares the character LCD controller (lcd_interface) between NREQ frame requesters, for example the SPI message path and local status sources. It grants one requester at a time in round-robin order. For the granted requester it sequences the full frame write: clear, 16 line-1 characters, line-2 address command 0xC0, then 16 line-2 characters. It sits between the requesters and lcd_interface, in the same clock domain as the LCD controller.

Parameters:
NREQ, 2, number of requesters (2..4)
COLS, 16, characters per line; frame length is 2*COLS
BUSY_TIMEOUT, 1023, maximum cycles spent waiting on each busy edge
FILL_CHAR, 8'h20, character substituted for a 0x00 frame byte

Ports:
clk  in  1  system clock (single clock)
rst  in  1  synchronous, active-high reset
req  in  NREQ  frame request per requester; level-sensitive, sampled only in IDLE
grant  out  NREQ  one-hot; held from frame start until done
done  out  NREQ  one-cycle pulse to the granted requester at frame end
rd_idx  out  5  character index 0..2*COLS-1 requested from the granted source
rd_data  in  NREQ*8  per-requester character bus; slice k belongs to requester k; valid 1 cycle after rd_idx changes
lcd_data  out  8  character or command byte to lcd_interface
lcd_send_data  out  1  one-cycle strobe: write lcd_data with RS=1
lcd_send_cmd  out  1  one-cycle strobe: write lcd_data with RS=0
lcd_clear  out  1  one-cycle strobe: clear display
lcd_busy  in  1  lcd_interface busy
active  out  1  high while a frame is in progress
timeout_err  out  1  sticky; set on any busy timeout, cleared only by rst

Behaviour:
- Reset values: every output 0, rr pointer set so requester 0 has top priority, FSM in IDLE, timeout counter 0.
- All outputs are registered. Every strobe lasts exactly one cycle, and at most one strobe is asserted in any cycle.
- Strobe rule: a strobe is issued only in a cycle where lcd_busy is sampled 0. Otherwise the FSM holds its state.
- Wait rule after each strobe:
  - W_RISE: wait for lcd_busy=1, then go to W_FALL.
  - W_FALL: wait for lcd_busy=0, then take the next step.
  - A counter runs in each wait phase. When it reaches BUSY_TIMEOUT, the FSM sets timeout_err and advances as if the edge had been seen.
- FSM states: IDLE, CLEAR, CLR_WAIT, FETCH, SEND, CHR_WAIT, LINE2, L2_WAIT, DONE.
- IDLE:
  - If any req bit is high, grant the winner next cycle, raise active, go to CLEAR.
  - The winner is the first set bit at or after (last_grant+1) mod NREQ.
- CLEAR: issue lcd_clear, then CLR_WAIT. CLR_WAIT: apply the wait rule, set idx=0, then FETCH.
- FETCH: drive rd_idx=idx, then move to SEND one cycle later, which covers the 1-cycle read latency.
- SEND:
  - Capture the granted slice of rd_data. A 0x00 byte is replaced by FILL_CHAR.
  - Issue lcd_send_data with that byte on lcd_data, then go to CHR_WAIT.
- CHR_WAIT: apply the wait rule, then:
  - if idx==2*COLS-1, go to DONE;
  - else if idx==COLS-1, idx++ and go to LINE2;
  - else idx++ and go to FETCH.
- LINE2: issue lcd_send_cmd with lcd_data=0xC0, then L2_WAIT. L2_WAIT: apply the wait rule, then FETCH.
- DONE:
  - Pulse done on the granted bit; clear grant and active in the same cycle.
  - Update last_grant and return to IDLE. A new grant is possible on the following cycle.
- Boundary conditions:
  - A requester dropping req mid-frame has no effect; the frame completes.
  - req rising mid-frame is served at the next IDLE.
  - If all req bits are high continuously, grants rotate 0,1,...,NREQ-1,0.
  - A single requester holding req high is re-granted back to back.
  - rst mid-frame aborts immediately: no done pulse, no further strobes, pointer reset.
- Per-frame strobe totals: exactly 1 clear, 2*COLS data writes and 1 command.

Decomposition:
- Shared package lcd_sched_pkg holds:
  - the FSM state enum;
  - LCD_CMD_LINE2 = 8'hC0;
  - default FILL_CHAR;
  - the frame length constant.
- One sub-module, rr_arbiter: inputs req, last_grant and en; output one-hot grant. It is purely combinational, and the parent registers its output.

Test Plan:
- req=01, model busy high 3 cycles after each strobe -> sequence 1 clear, 16 data, cmd 0xC0, 16 data; rd_idx sweeps 0..31; done=01 for one cycle; active low afterwards.
- Source frame bytes 0x41 with index 5 = 0x00 -> 6th data write is 0x20; all others 0x41.
- req=11 held for 3 frames -> grants 01, 10, 01; done pulses match; grant is never two-hot.
- lcd_busy held 1 from start -> no strobe issued; clear goes out on the first cycle busy drops to 0.
- lcd_busy stuck 0 -> each wait times out after 1023 cycles; timeout_err=1 and stays set; the frame still completes with 34 strobes.
- rst asserted after the 10th data write -> the next cycle has all outputs 0 and no done pulse; with req=11 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/lcd_sched_pkg.sv
// Shared state encoding and constants for the LCD frame scheduler.
// A frame is: clear, COLS line-1 chars, line-2 address command, COLS line-2 chars.
package lcd_sched_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        CLR_WAIT,
        FETCH,
        SEND,
        CHR_WAIT,
        LINE2,
        L2_WAIT,
        DONE
    } sched_state_t;

    localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
    localparam logic [7:0] FILL_CHAR_DEF = 8'h20;
    localparam int         FRAME_LEN     = 32;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lcd_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after last_grant+1.
// Zero latency; caller registers the one-hot result.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_grant,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (en && !found && req[j] && (((int'(last_grant) + i) % NREQ) == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Grants one requester at a time and streams its frame into the LCD controller.
// All outputs registered; each strobe waits for lcd_busy low, then a busy rise/fall (bounded).
module lcd_frame_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int         NREQ         = 2,
    parameter int         COLS         = FRAME_LEN / 2,
    parameter int         BUSY_TIMEOUT = 1023,
    parameter logic [7:0] FILL_CHAR    = FILL_CHAR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [4:0]        rd_idx,
    input  logic [NREQ*8-1:0] rd_data,
    output logic [7:0]        lcd_data,
    output logic              lcd_send_data,
    output logic              lcd_send_cmd,
    output logic              lcd_clear,
    input  logic              lcd_busy,
    output logic              active,
    output logic              timeout_err
);

    localparam int         WCW      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [4:0] IDX_LAST = 5'(2 * COLS - 1);
    localparam logic [4:0] IDX_L1   = 5'(COLS - 1);

    sched_state_t    state, state_d;
    logic [4:0]      idx, idx_d;
    logic [WCW-1:0]  wcnt, wcnt_d;
    logic            wait_fall, fall_d;
    logic [1:0]      last_grant, last_grant_d;
    logic [NREQ-1:0] grant_d, done_d, arb_grant;
    logic [7:0]      lcd_data_d, raw_byte, char_byte;
    logic            send_data_d, send_cmd_d, clear_d, active_d, timeout_d;
    logic            edge_seen, expired, wait_exit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .grant      (arb_grant)
    );

    assign rd_idx    = idx;
    assign edge_seen = wait_fall ? !lcd_busy : lcd_busy;
    assign expired   = (wcnt == WCW'(BUSY_TIMEOUT - 1));

    always_comb begin
        raw_byte = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) raw_byte = rd_data[8*k +: 8];
        end
    end

    assign char_byte = (raw_byte == 8'h00) ? FILL_CHAR : raw_byte;

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        done_d       = '0;
        idx_d        = idx;
        lcd_data_d   = lcd_data;
        send_data_d  = 1'b0;
        send_cmd_d   = 1'b0;
        clear_d      = 1'b0;
        active_d     = active;
        timeout_d    = timeout_err;
        wcnt_d       = wcnt;
        fall_d       = wait_fall;
        last_grant_d = last_grant;
        wait_exit    = 1'b0;

        // Shared rise-then-fall wait; a timeout counts as having seen the edge.
        if (state inside {CLR_WAIT, CHR_WAIT, L2_WAIT}) begin
            if (edge_seen || expired) begin
                wcnt_d    = '0;
                fall_d    = !wait_fall;
                wait_exit = wait_fall;
                if (!edge_seen) timeout_d = 1'b1;
            end else begin
                wcnt_d = wcnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (|req) begin
                    grant_d  = arb_grant;
                    active_d = 1'b1;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                if (!lcd_busy) begin
                    clear_d = 1'b1;
                    state_d = CLR_WAIT;
                end
            end
            CLR_WAIT: begin
                if (wait_exit) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = SEND;
            SEND: begin
                if (!lcd_busy) begin
                    lcd_data_d  = char_byte;
                    send_data_d = 1'b1;
                    state_d     = CHR_WAIT;
                end
            end
            CHR_WAIT: begin
                if (wait_exit) begin
                    if (idx == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = (idx == IDX_L1) ? LINE2 : FETCH;
                    end
                end
            end
            LINE2: begin
                if (!lcd_busy) begin
                    lcd_data_d = LCD_CMD_LINE2;
                    send_cmd_d = 1'b1;
                    state_d    = L2_WAIT;
                end
            end
            L2_WAIT: begin
                if (wait_exit) state_d = FETCH;
            end
            DONE: begin
                done_d       = grant;
                grant_d      = '0;
                active_d     = 1'b0;
                idx_d        = '0;
                last_grant_d = onehot_to_idx(4'(grant));
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            done          <= '0;
            idx           <= '0;
            lcd_data      <= '0;
            lcd_send_data <= 1'b0;
            lcd_send_cmd  <= 1'b0;
            lcd_clear     <= 1'b0;
            active        <= 1'b0;
            timeout_err   <= 1'b0;
            wcnt          <= '0;
            wait_fall     <= 1'b0;
            last_grant    <= 2'(NREQ - 1);
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            done          <= done_d;
            idx           <= idx_d;
            lcd_data      <= lcd_data_d;
            lcd_send_data <= send_data_d;
            lcd_send_cmd  <= send_cmd_d;
            lcd_clear     <= clear_d;
            active        <= active_d;
            timeout_err   <= timeout_d;
            wcnt          <= wcnt_d;
            wait_fall     <= fall_d;
            last_grant    <= last_grant_d;
        end
    end

endmodule
